// File: rtl/audio_pkg.sv
// Shared constants and types for the stereo PDM-to-I2S audio chain.
package audio_pkg;

   localparam int PCM_W    = 16;
   localparam int PCM_SLOT = 32;

   typedef struct packed {
      logic signed [PCM_W-1:0] left;
      logic signed [PCM_W-1:0] right;
   } stereo_frame_t;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tx_state_t;

endpackage

// File: rtl/pcm_frame_fifo.sv
// Small stereo frame FIFO. A push on a full FIFO is accepted only when a pop
// frees a slot in the same cycle; a pop on an empty FIFO never bypasses a push.
module pcm_frame_fifo
   import audio_pkg::*;
#(
   parameter int FW    = $bits(stereo_frame_t),
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [FW-1:0]              din,
   input  logic                       pop,
   output logic [FW-1:0]              dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [FW-1:0] mem_q [DEPTH];
   logic [FW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0] level_q, level_d;
   logic          wr_en, rd_en;

   assign empty = (level_q == '0);
   assign full  = (level_q == LW'(DEPTH));
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign dout  = mem_q[rd_q];
   assign level = level_q;

   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      level_d = level_q;
      if (wr_en) begin
         mem_d[wr_q] = din;
         wr_d        = wr_q + AW'(1);
      end
      if (rd_en)
         rd_d = rd_q + AW'(1);
      if (wr_en && !rd_en)
         level_d = level_q + LW'(1);
      else if (!wr_en && rd_en)
         level_d = level_q - LW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q   <= '{default: '0};
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/pcm_i2s_tx.sv
// Buffers stereo PCM pairs and serialises them as I2S (bclk/lrclk/sdata).
// Define PCM_TX_LEFT_JUSTIFIED_EN for left-justified framing (lrclk high = left).
module pcm_i2s_tx
   import audio_pkg::*;
#(
   parameter int W        = PCM_W,
   parameter int SLOT     = PCM_SLOT,
   parameter int BCLK_DIV = 10,
   parameter int DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en_pcm,
   input  logic [W-1:0]               din_left,
   input  logic [W-1:0]               din_right,
   output logic                       bclk,
   output logic                       lrclk,
   output logic                       sdata,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic                       overrun,
   output logic                       underrun
);

   localparam int HW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int BW = $clog2(2*SLOT);
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [BW-1:0] LAST_BIT = BW'(2*SLOT-1);
   localparam logic [BW-1:0] SLOT_B   = BW'(SLOT);
   localparam logic [BW-1:0] W_B      = BW'(W);

   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [BW-1:0] bitcnt_q, bitcnt_d;
   logic          bclk_q, bclk_d, lrclk_q, lrclk_d, sdata_q, sdata_d;
   logic          overrun_q, overrun_d, underrun_q, underrun_d;
   tx_state_t     state_q, state_d;
   logic [W-1:0]  frm_l_q, frm_l_d, frm_r_q, frm_r_d;

   logic          tick, fall, boundary, pop;
   logic          fifo_full, fifo_empty;
   logic [2*W-1:0] fifo_dout;
   logic          ch;
   logic [BW-1:0] s_idx;
   logic [W-1:0]  word, shifted;

   pcm_frame_fifo #(.FW(2*W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (en_pcm),
      .din   ({din_left, din_right}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign tick     = (hcnt_q == HW'(BCLK_DIV-1));
   assign fall     = tick && bclk_q;
   assign boundary = fall && (bitcnt_q == LAST_BIT);

   always_comb begin
      hcnt_d     = tick ? '0 : hcnt_q + HW'(1);
      bclk_d     = tick ? ~bclk_q : bclk_q;
      bitcnt_d   = bitcnt_q;
      state_d    = state_q;
      frm_l_d    = frm_l_q;
      frm_r_d    = frm_r_q;
      pop        = 1'b0;
      underrun_d = 1'b0;
      // A full FIFO always has data, so a concurrent pop frees the slot.
      overrun_d  = en_pcm && fifo_full && !pop;
      if (fall)
         bitcnt_d = boundary ? '0 : bitcnt_q + BW'(1);
      if (boundary) begin
         case (state_q)
            IDLE: begin
               if (level >= LW'(2)) begin
                  pop     = 1'b1;
                  frm_l_d = fifo_dout[2*W-1:W];
                  frm_r_d = fifo_dout[W-1:0];
                  state_d = RUN;
               end
            end
            RUN: begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  frm_l_d = fifo_dout[2*W-1:W];
                  frm_r_d = fifo_dout[W-1:0];
               end else begin
                  frm_l_d    = '0;
                  frm_r_d    = '0;
                  underrun_d = 1'b1;
                  state_d    = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      overrun_d = en_pcm && fifo_full && !pop;
   end

   // Output bit is chosen from the post-tick bit position and frame.
   assign ch      = (bitcnt_d >= SLOT_B);
   assign s_idx   = ch ? bitcnt_d - SLOT_B : bitcnt_d;
   assign word    = ch ? frm_r_d : frm_l_d;
   assign shifted = word << s_idx;

   always_comb begin
      lrclk_d = lrclk_q;
      sdata_d = sdata_q;
      if (fall) begin
         sdata_d = (s_idx < W_B) && shifted[W-1];
`ifdef PCM_TX_LEFT_JUSTIFIED_EN
         lrclk_d = !ch;
`else
         lrclk_d = (((bitcnt_d == LAST_BIT) ? '0 : bitcnt_d + BW'(1)) >= SLOT_B);
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt_q     <= '0;
         bitcnt_q   <= LAST_BIT;
         bclk_q     <= 1'b0;
         lrclk_q    <= 1'b0;
         sdata_q    <= 1'b0;
         overrun_q  <= 1'b0;
         underrun_q <= 1'b0;
         state_q    <= IDLE;
         frm_l_q    <= '0;
         frm_r_q    <= '0;
      end else begin
         hcnt_q     <= hcnt_d;
         bitcnt_q   <= bitcnt_d;
         bclk_q     <= bclk_d;
         lrclk_q    <= lrclk_d;
         sdata_q    <= sdata_d;
         overrun_q  <= overrun_d;
         underrun_q <= underrun_d;
         state_q    <= state_d;
         frm_l_q    <= frm_l_d;
         frm_r_q    <= frm_r_d;
      end
   end

   assign bclk     = bclk_q;
   assign lrclk    = lrclk_q;
   assign sdata    = sdata_q;
   assign overrun  = overrun_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_pcm_i2s_tx.sv
// Directed bench for pcm_i2s_tx: captures the serial stream on bclk rises and
// checks framing, FIFO level, overrun/underrun pulses and async reset.
module tb_pcm_i2s_tx;

   localparam int W = 16, SLOT = 32, BCLK_DIV = 10, DEPTH = 4;

   logic         clk = 1'b0, rst = 1'b1, en_pcm = 1'b0;
   logic [W-1:0] din_left = '0, din_right = '0;
   logic         bclk, lrclk, sdata, overrun, underrun;
   logic [2:0]   level;

   int checks = 0, errors = 0;
   int cyc = 0, ur_cnt = 0, ov_cnt = 0, bpos = 63, rise_cyc = 0, prev_rise = 0;
   logic [63:0]  sd_a = '0, lr_a = '0, lr_exp = '0;
   logic [15:0]  al [8];
   logic [15:0]  ar [8];

   always #5 clk = ~clk;

   pcm_i2s_tx #(.W(W), .SLOT(SLOT), .BCLK_DIV(BCLK_DIV), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .en_pcm    (en_pcm),
      .din_left  (din_left),
      .din_right (din_right),
      .bclk      (bclk),
      .lrclk     (lrclk),
      .sdata     (sdata),
      .level     (level),
      .overrun   (overrun),
      .underrun  (underrun)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (underrun === 1'b1) ur_cnt++;
      if (overrun === 1'b1) ov_cnt++;
   endtask

   // Wait for the next bclk rise and record the bit the receiver would sample.
   task automatic grab();
      logic seen0, got;
      seen0 = 1'b0;
      got   = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         step();
         if (bclk === 1'b0) seen0 = 1'b1;
         else if (seen0) got = 1'b1;
      end
      if (!got) chk("bclk_rise_timeout", {63'd0, got}, 64'd1);
      sd_a[bpos] = sdata;
      lr_a[bpos] = lrclk;
      prev_rise  = rise_cyc;
      rise_cyc   = cyc;
      bpos       = (bpos + 1) % 64;
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) grab();
   endtask

   task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
      din_left  = l;
      din_right = r;
      en_pcm    = 1'b1;
      step();
      en_pcm    = 1'b0;
   endtask

   task automatic check_frame(input string tag, input logic [W-1:0] l, input logic [W-1:0] r);
      logic [W-1:0] gl, gr;
      for (int s = 0; s < W; s++) begin
         gl[W-1-s] = sd_a[s];
         gr[W-1-s] = sd_a[SLOT+s];
      end
      chk({tag, "_left"}, {48'd0, gl}, {48'd0, l});
      chk({tag, "_right"}, {48'd0, gr}, {48'd0, r});
      chk({tag, "_pad"}, {32'd0, sd_a[63:48], sd_a[31:16]}, 64'd0);
      chk({tag, "_lrclk"}, lr_a, lr_exp);
   endtask

   initial begin
      al = '{16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'hA5A5, 16'hC3C3, 16'h0F0F};
      ar = '{16'hEDCB, 16'hDCBA, 16'hCBA9, 16'hBA98, 16'hA987, 16'h5A5A, 16'hFFFF, 16'hF0F0};
      for (int b = 0; b < 64; b++) begin
`ifdef PCM_TX_LEFT_JUSTIFIED_EN
         lr_exp[b] = (b < 32);
`else
         lr_exp[b] = (((b + 1) % 64) >= 32);
`endif
      end

      // Reset state, then three idle frames of zeros.
      repeat (3) step();
      chk("reset_outs", {56'd0, bclk, lrclk, sdata, overrun, underrun, level}, 64'd0);
      rst = 1'b0;
      capture(1);
      capture(1);
      chk("bclk_period", 64'(rise_cyc - prev_rise), 64'd20);
      capture(63);
      check_frame("idle0", '0, '0);
      capture(64);
      check_frame("idle1", '0, '0);
      capture(32);
      chk("idle_level", {61'd0, level}, 64'd0);
      push(16'h8001, 16'h7FFE);
      push(16'h8001, 16'h7FFE);
      chk("level_two", {61'd0, level}, 64'd2);
      capture(32);
      check_frame("idle2", '0, '0);
      chk("idle_no_underrun", 64'(ur_cnt), 64'd0);

      // Two queued frames play out, then one underrun and a zero frame.
      capture(64);
      check_frame("run_a", 16'h8001, 16'h7FFE);
      chk("level_after_pop", {61'd0, level}, 64'd1);
      capture(64);
      check_frame("run_b", 16'h8001, 16'h7FFE);
      chk("level_drained", {61'd0, level}, 64'd0);
      chk("no_underrun_yet", 64'(ur_cnt), 64'd0);
      capture(64);
      check_frame("urun_zero", '0, '0);
      chk("underrun_once", 64'(ur_cnt), 64'd1);

      // Overrun: five back-to-back pushes into a 4-deep FIFO while idle.
      capture(32);
      for (int k = 0; k < 5; k++) push(al[k], ar[k]);
      step();
      chk("level_full", {61'd0, level}, 64'd4);
      capture(32);
      check_frame("idle_after_urun", '0, '0);
      chk("overrun_once", 64'(ov_cnt), 64'd1);
      chk("no_underrun_in_idle", 64'(ur_cnt), 64'd1);

      // Refill to full, then push exactly on the boundary pop.
      capture(32);
      push(al[5], ar[5]);
      chk("level_refull", {61'd0, level}, 64'd4);
      capture(32);
      check_frame("fifo_a1", al[0], ar[0]);
      repeat (9) step();
      push(al[6], ar[6]);
      chk("boundary_push_level", {61'd0, level}, 64'd4);
      chk("boundary_push_no_overrun", 64'(ov_cnt), 64'd1);
      capture(64);
      check_frame("fifo_a2", al[1], ar[1]);
      capture(64);
      check_frame("fifo_a3", al[2], ar[2]);
      capture(64);
      check_frame("fifo_a4", al[3], ar[3]);
      capture(64);
      check_frame("fifo_a6", al[5], ar[5]);
      chk("no_extra_underrun", 64'(ur_cnt), 64'd1);

      // Async reset in the middle of the right slot of the last frame.
      capture(40);
      push(al[7], ar[7]);
      chk("pre_reset", {61'd0, bclk, sdata, level == 3'd1}, 64'd7);
      #3 rst = 1'b1;
      #1 chk("async_reset", {60'd0, bclk, lrclk, sdata, overrun, underrun, level}, 64'd0);
      repeat (2) step();
      rst = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
